// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse measurement stage.
package pulse_meter_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned WINDOW_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_REPORT  = 2'd2;

    // All-ones value of a w-bit counter, used as the saturation ceiling.
    function automatic logic [31:0] sat_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_meter_edge_sync.sv
// Two-flop synchronizer plus history flop; flags a rising edge of d.
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Synchronize the asynchronous input and keep one cycle of history.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_prev;

endmodule

// File: rtl/pulse_meter.sv
// Counts rising edges of pulse_in over a gated window and measures the last edge spacing.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] period,
    output logic             overflow
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(sat_max(CNT_W));
    localparam logic [WIN_W-1:0] C_WLD  = WIN_W'(WINDOW - 1);

    logic w_rise;

    state_t           r_state,    w_state_nxt;
    logic [WIN_W-1:0] r_win,      w_win_nxt;
    logic [CNT_W-1:0] r_wcnt,     w_wcnt_nxt;
    logic [CNT_W-1:0] r_gap,      w_gap_nxt;
    logic             r_seen,     w_seen_nxt;
    logic [CNT_W-1:0] r_wper,     w_wper_nxt;
    logic             r_wovf,     w_wovf_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic [CNT_W-1:0] r_count,    w_count_nxt;
    logic [CNT_W-1:0] r_period,   w_period_nxt;
    logic             r_overflow, w_overflow_nxt;

    edge_sync u_edge_sync (
        .clock (clock),
        .reset (reset),
        .d     (pulse_in),
        .rise  (w_rise)
    );

    // State, working counters and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_win      <= '0;
            r_wcnt     <= '0;
            r_gap      <= '0;
            r_seen     <= 1'b0;
            r_wper     <= '0;
            r_wovf     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_period   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_win      <= w_win_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_gap      <= w_gap_nxt;
            r_seen     <= w_seen_nxt;
            r_wper     <= w_wper_nxt;
            r_wovf     <= w_wovf_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_count    <= w_count_nxt;
            r_period   <= w_period_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Next-state, window datapath and result capture.
    always_comb begin
        w_state_nxt    = r_state;
        w_win_nxt      = r_win;
        w_wcnt_nxt     = r_wcnt;
        w_gap_nxt      = r_gap;
        w_seen_nxt     = r_seen;
        w_wper_nxt     = r_wper;
        w_wovf_nxt     = r_wovf;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_count_nxt    = r_count;
        w_period_nxt   = r_period;
        w_overflow_nxt = r_overflow;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_MEASURE;
                    w_win_nxt   = C_WLD;
                    w_wcnt_nxt  = '0;
                    w_gap_nxt   = '0;
                    w_seen_nxt  = 1'b0;
                    w_wper_nxt  = '0;
                    w_wovf_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            ST_MEASURE: begin
                if (r_gap != C_MAX) begin
                    w_gap_nxt = r_gap + CNT_W'(1);
                end
                if (w_rise) begin
                    if (r_wcnt == C_MAX) begin
                        w_wovf_nxt = 1'b1;
                    end else begin
                        w_wcnt_nxt = r_wcnt + CNT_W'(1);
                    end
                    if (r_seen) begin
                        if (r_gap == C_MAX) begin
                            w_wper_nxt = C_MAX;
                            w_wovf_nxt = 1'b1;
                        end else begin
                            w_wper_nxt = r_gap + CNT_W'(1);
                        end
                    end
                    w_gap_nxt  = '0;
                    w_seen_nxt = 1'b1;
                end
                // Results are captured on the way into REPORT so they are valid with done.
                if (r_win == '0) begin
                    w_state_nxt    = ST_REPORT;
                    w_done_nxt     = 1'b1;
                    w_count_nxt    = w_wcnt_nxt;
                    w_period_nxt   = w_wper_nxt;
                    w_overflow_nxt = w_wovf_nxt;
                end else begin
                    w_win_nxt  = r_win - WIN_W'(1);
                    w_busy_nxt = 1'b1;
                end
            end

            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign period   = r_period;
    assign overflow = r_overflow;

endmodule
